// File: rtl/dma_copy.sv
// dma_copy: byte-serial memory-to-memory copy engine on a shared synchronous bus.
// Define DMA_FILL_EN to add fill mode (cmd_fill input, FILL state writing a constant byte).
module dma_copy (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_src,
    input  logic [15:0] cmd_dst,
    input  logic [15:0] cmd_len,
`ifdef DMA_FILL_EN
    input  logic        cmd_fill,
`endif
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        bus_we
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        FINISH
`ifdef DMA_FILL_EN
        , FILL
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] src_q, dst_q, len_q;
    logic [7:0]  data_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        step;
    logic        step_src;
    logic        last_byte;

    assign last_byte = (len_q == 16'd1);

    // Address and write data are combinational in granted cycles so the memory sees them in
    // the same cycle; otherwise they replay the registered copy of the last bus cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        step      = 1'b0;
        step_src  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_len == 16'd0)
                        state_d = FINISH;
`ifdef DMA_FILL_EN
                    else if (cmd_fill)
                        state_d = FILL;
`endif
                    else
                        state_d = READ;
                end
            end
            READ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    bus_addr = src_q;
                    state_d  = LATCH;
                end
            end
            LATCH: begin
                bus_req = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    bus_addr  = dst_q;
                    bus_wdata = data_q;
                    bus_we    = 1'b1;
                    step      = 1'b1;
                    step_src  = 1'b1;
                    state_d   = last_byte ? FINISH : READ;
                end
            end
`ifdef DMA_FILL_EN
            FILL: begin
                // Fill byte lives in src_q[7:0]; src_q is never stepped in this mode.
                bus_req = 1'b1;
                if (bus_gnt) begin
                    bus_addr  = dst_q;
                    bus_wdata = src_q[7:0];
                    bus_we    = 1'b1;
                    step      = 1'b1;
                    state_d   = last_byte ? FINISH : FILL;
                end
            end
`endif
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= 16'h0000;
            dst_q   <= 16'h0000;
            len_q   <= 16'h0000;
            data_q  <= 8'h00;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= bus_addr;
            wdata_q <= bus_wdata;
            if (cmd_ready && cmd_valid) begin
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                len_q <= cmd_len;
            end else if (step) begin
                dst_q <= dst_q + 16'd1;
                len_q <= len_q - 16'd1;
                if (step_src)
                    src_q <= src_q + 16'd1;
            end
            if (state_q == LATCH)
                data_q <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: directed and randomized checks of dma_copy against a byte-array reference model.
// Define DMA_FILL_EN for both files to exercise fill mode as well.
module tb_dma_copy;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_src = 16'h0;
    logic [15:0] cmd_dst = 16'h0;
    logic [15:0] cmd_len = 16'h0;
`ifdef DMA_FILL_EN
    logic        cmd_fill = 1'b0;
`endif
    logic        busy, done, bus_req, bus_we;
    logic        bus_gnt = 1'b1;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dma_copy dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
`ifdef DMA_FILL_EN
        .cmd_fill  (cmd_fill),
`endif
        .busy      (busy),
        .done      (done),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_we    (bus_we)
    );

    // Bus memory: untouched bytes read as a seeded hash of the address.
    logic [7:0] seed = 8'h00;
    bit         mem_wr  [0:65535];
    logic [7:0] mem_dat [0:65535];

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return (a[7:0] * 8'd29) ^ (a[15:8] * 8'd113) ^ seed;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return mem_wr[a] ? mem_dat[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        if (bus_we) begin
            mem_wr[bus_addr]  <= 1'b1;
            mem_dat[bus_addr] <= bus_wdata;
        end
        bus_rdata <= mem_rd(bus_addr);
    end

    // Reference model: what memory must contain after each command.
    bit         model_wr  [0:65535];
    logic [7:0] model_dat [0:65535];
    bit         gpat      [0:511];
    logic [23:0] exp_q[$];
    logic [23:0] wlog[$];
    int          last_done;

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        return model_wr[a] ? model_dat[a] : init_byte(a);
    endfunction

    // Cycle (1 = first cycle after accept) in which done must be high, given grant pattern gpat.
    function automatic int model_done_cycle(input logic [15:0] len, input bit fill);
        int t = 1;
        for (int i = 0; i < int'(len); i++) begin
            if (!fill) begin
                while (t < 511 && !gpat[t]) t++;
                t += 2;
            end
            while (t < 511 && !gpat[t]) t++;
            t++;
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic gnt_all(input bit v);
        for (int i = 0; i < 512; i++) gpat[i] = v;
    endtask

    task automatic gnt_random();
        for (int i = 0; i < 512; i++) gpat[i] = ($urandom_range(0, 3) != 0);
    endtask

    // Issue one command from IDLE, run it to done and compare everything against the model.
    task automatic run_cmd(input string name, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len, input bit fill, input bit junk);
        int n, done_cyc, exp_cyc, req_cnt, we_cnt, we_ungr, rd_cnt;
        logic [7:0]  d;
        logic [23:0] last_w;
        exp_q.delete();
        wlog.delete();
        exp_cyc = model_done_cycle(len, fill);
        for (int i = 0; i < int'(len); i++) begin
            logic [15:0] da;
            da = dst + 16'(i);
            d  = fill ? src[7:0] : model_rd(src + 16'(i));
            model_wr[da]  = 1'b1;
            model_dat[da] = d;
            exp_q.push_back({da, d});
        end
        cmd_valid = 1'b1;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
`ifdef DMA_FILL_EN
        cmd_fill  = fill;
`endif
        @(posedge clk); #1;
        n = 1; done_cyc = -1; req_cnt = 0; we_cnt = 0; we_ungr = 0; rd_cnt = 0;
        while (done_cyc < 0 && n < 400) begin
            bus_gnt   = gpat[n];
            cmd_valid = junk;
            if (junk) begin
                cmd_src = 16'($urandom);
                cmd_dst = 16'($urandom);
                cmd_len = 16'($urandom_range(1, 5));
            end
            @(negedge clk);
            if (bus_req) req_cnt++;
            if (bus_we) begin
                we_cnt++;
                wlog.push_back({bus_addr, bus_wdata});
                if (!bus_gnt) we_ungr++;
            end
            if (bus_req && bus_gnt && !bus_we) rd_cnt++;
            if (done) done_cyc = n;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        bus_gnt   = 1'b1;
        last_done = done_cyc;
        check({name, ":done_cycle"}, done_cyc, exp_cyc);
        check({name, ":ready_after"}, {31'd0, cmd_ready}, 32'd1);
        check({name, ":done_pulse"}, {31'd0, done}, 32'd0);
        check({name, ":we_count"}, we_cnt, {16'd0, len});
        check({name, ":we_ungranted"}, we_ungr, 0);
        check({name, ":log_size"}, wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            check($sformatf("%s:write%0d", name, i), {8'd0, wlog[i]}, {8'd0, exp_q[i]});
        for (int i = 0; i < int'(len); i++)
            check($sformatf("%s:mem%0d", name, i), {24'd0, mem_rd(dst + 16'(i))},
                  {24'd0, model_rd(dst + 16'(i))});
        if (len == 16'd0)
            check({name, ":no_req"}, req_cnt, 0);
        else begin
            last_w = exp_q[exp_q.size() - 1];
            check({name, ":addr_hold"}, {16'd0, bus_addr}, {16'd0, last_w[23:8]});
            check({name, ":wdata_hold"}, {24'd0, bus_wdata}, {24'd0, last_w[7:0]});
        end
        if (fill)
            check({name, ":no_reads"}, rd_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        seed = 8'($urandom);
        #12;
        check("rst:cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst:busy", {31'd0, busy}, 32'd0);
        check("rst:done", {31'd0, done}, 32'd0);
        check("rst:bus_req", {31'd0, bus_req}, 32'd0);
        check("rst:bus_we", {31'd0, bus_we}, 32'd0);
        check("rst:bus_addr", {16'd0, bus_addr}, 32'd0);
        check("rst:bus_wdata", {24'd0, bus_wdata}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        gnt_all(1'b1);
        run_cmd("basic", 16'h0010, 16'h0200, 16'd4, 1'b0, 1'b0);
        check("basic:cycle13", last_done, 13);
        run_cmd("len0", 16'h1111, 16'h2222, 16'd0, 1'b0, 1'b0);
        check("len0:cycle1", last_done, 1);
        run_cmd("wrap_dst", 16'h0800, 16'hFFFF, 16'd2, 1'b0, 1'b0);
        run_cmd("wrap_src", 16'hFFFE, 16'h0900, 16'd3, 1'b0, 1'b0);

        for (int i = 3; i <= 7; i++) gpat[i] = 1'b0;
        run_cmd("gnt_stall", 16'h0020, 16'h0220, 16'd4, 1'b0, 1'b0);
        check("gnt_stall:cycle18", last_done, 18);
        gnt_all(1'b1);

        run_cmd("overlap", 16'h0300, 16'h0302, 16'd6, 1'b0, 1'b0);

        // Reset during LATCH of byte 2 of an 8-byte copy.
        cmd_valid = 1'b1;
        cmd_src   = 16'h0400;
        cmd_dst   = 16'h0500;
        cmd_len   = 16'd8;
`ifdef DMA_FILL_EN
        cmd_fill  = 1'b0;
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("midrst:busy_before", {31'd0, busy}, 32'd1);
        check("midrst:req_before", {31'd0, bus_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst:busy", {31'd0, busy}, 32'd0);
        check("midrst:ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst:bus_req", {31'd0, bus_req}, 32'd0);
        check("midrst:bus_we", {31'd0, bus_we}, 32'd0);
        check("midrst:bus_addr", {16'd0, bus_addr}, 32'd0);
        check("midrst:bus_wdata", {24'd0, bus_wdata}, 32'd0);
        model_wr[16'h0500]  = 1'b1;
        model_dat[16'h0500] = model_rd(16'h0400);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("midrst:no_done", {31'd0, saw_done}, 32'd0);
        check("midrst:byte0", {24'd0, mem_rd(16'h0500)}, {24'd0, model_rd(16'h0500)});
        check("midrst:byte1", {24'd0, mem_rd(16'h0501)}, {24'd0, model_rd(16'h0501)});
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_cmd("post_rst", 16'h0600, 16'h0700, 16'd3, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            gnt_random();
            run_cmd($sformatf("rnd%0d", k), 16'($urandom), 16'($urandom),
                    16'($urandom_range(0, 10)), 1'b0, 1'b1);
        end

`ifdef DMA_FILL_EN
        gnt_all(1'b1);
        run_cmd("fill", 16'h00A5, 16'h0100, 16'd3, 1'b1, 1'b0);
        check("fill:cycle4", last_done, 4);
        run_cmd("fill_len0", 16'h005A, 16'h0100, 16'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            gnt_random();
            run_cmd($sformatf("fill_rnd%0d", k), 16'($urandom), 16'($urandom),
                    16'($urandom_range(1, 8)), 1'b1, 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
